gpio_wb_ctrl: RTL
=================

Name: gpio_wb_ctrl

Overview:
- Wishbone-slave GPIO controller inside the user project area, directly upstream of the mprj_io pads.
- Firmware on the management SoC writes output and output-enable registers that drive io_out/io_oeb.
- Samples io_in through a two-flop synchroniser and raises a rising-edge interrupt.
- The chip-level IO-ports bench observes its outputs, e.g. mprj_io[31:0] = 0x12345678.

Parameters:
- NUM_IO, 38, number of IO bits; legal range 33..64, bits [NUM_IO-1:32] live in the _HI registers.
- BASE_ADR, 32'h3000_0000, Wishbone base address; the register window is BASE_ADR+0x00..0x1F.

Ports:
- wb_clk_i  in  1  Wishbone/system clock, all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  NUM_IO  pad input values (asynchronous).
- io_out  out  NUM_IO  pad output values.
- io_oeb  out  NUM_IO  pad output-enable, active low.
- irq  out  1  level interrupt to the management SoC.

Behaviour:
- Reset (async assert, sync release): io_out=0; io_oeb=all 1 (all inputs); IRQ_EN=0; IRQ_STAT=0; sync flops=0; wbs_ack_o=0; wbs_dat_o=0; irq=0.
- Register map (offset: name, access):
  - 0x00 OUT_LO RW, bits 31:0; 0x04 OUT_HI RW, bits NUM_IO-1:32.
  - 0x08 OEB_LO RW; 0x0C OEB_HI RW.
  - 0x10 IN_LO RO (synchronised); 0x14 IN_HI RO.
  - 0x18 IRQ_EN RW, bits 31:0; 0x1C IRQ_STAT W1C, bits 31:0.
- HI registers: unimplemented bits read 0; writes to them are ignored.
- Handshake: transaction when cyc&stb&!ack.
  - wbs_ack_o asserts on the next rising edge for exactly one cycle, then deasserts for at least one cycle.
  - One access per two cycles; no wait states beyond that.
- Writes: take effect on the same edge that asserts ack; only byte lanes with wbs_sel_i[n]=1 update.
- Reads: wbs_dat_o is registered with ack and is valid while ack=1; it returns to 0 when ack falls.
- Out-of-window addresses (including BASE_ADR+0x20 and above): ack normally, read data 0, writes ignored. No bus hang.
- Address decode uses wbs_adr_i[31:5] against BASE_ADR[31:5]; bits [4:2] select the register; bits [1:0] are ignored.
- Synchroniser: s1<=io_in, s2<=s1, s3<=s2 every cycle.
  - IN reads return s2.
  - A change on io_in before edge N is visible in IN at edge N+1 (2-cycle latency).
- Edge detect: rise[i]=s2[i]&!s3[i] for i<32. IRQ_STAT[i] is set on rise[i] regardless of IRQ_EN.
- W1C: writing 1 to an IRQ_STAT bit (lane enabled) clears it. If the same bit has rise in that cycle, set wins (bit stays 1).
- irq is registered: irq <= |(IRQ_STAT & IRQ_EN).
  - Asserts one cycle after the status bit sets.
  - Deasserts one cycle after clear or disable.
- io_out/io_oeb are direct register outputs; no combinational path from the bus.
- Reset mid-transaction: ack drops immediately and the write is lost. After release, the master must re-issue the cycle.
- cyc deasserting while ack=1 has no side effect.

Test Plan:
- Reset: hold wb_rst_i, then release -> io_oeb=38'h3F_FFFF_FFFF, io_out=0, irq=0, wbs_ack_o=0; all register reads return 0 except OEB.
- Output drive: write OEB_LO=0, OUT_LO=0x12345678 -> io_out[31:0]=0x12345678 one edge after the write strobe, ack exactly 1 cycle; read back OUT_LO=0x12345678.
- Byte lanes / HI: write OUT_HI=0xFFFFFFFF with sel=4'b0001 -> io_out[37:32]=6'h3F, OUT_HI reads 0x0000003F; a subsequent write with sel=0 changes nothing.
- Input sync: drive io_in=0x0A5 -> IN_LO reads 0x0A5 no earlier than 2 edges after the change; an earlier read returns the old value.
- Interrupt: IRQ_EN=0x1, pulse io_in[0] 0→1 -> IRQ_STAT=0x1 and irq=1 one cycle later. Write 0x1 to IRQ_STAT -> irq=0. Repeat with the W1C coinciding with a new rise -> bit stays 1, irq stays 1.
- Decode: read BASE_ADR+0x20 and 0x3000_1000 -> ack with data 0; a write there changes no register.

Source files
------------

// File: rtl/gpio_wb_ctrl.sv
// Wishbone-slave GPIO controller for the user project pads: output/enable registers,
// synchronised inputs and a rising-edge interrupt on the low 32 bits.
module gpio_wb_ctrl #(
  parameter int unsigned NUM_IO   = 38,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq
);

  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] s1_q, s2_q;
  logic [31:0]       s3_q;
  logic [31:0]       irq_en_q, irq_en_d;
  logic [31:0]       irq_stat_q, irq_stat_d;
  logic [31:0]       dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              irq_q, irq_d;

  logic        req, hit, wr, rd;
  logic [2:0]  reg_sel;
  logic [31:0] lane_mask;
  logic [31:0] rise;
  logic [31:0] w1c;
  logic [63:0] out_ext, oeb_ext, in_ext;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit     = req && (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    wr      = hit & wbs_we_i;
    rd      = hit & ~wbs_we_i;
    reg_sel = wbs_adr_i[4:2];
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{wbs_sel_i[b]}};
    end

    // Zero-padded 64-bit views so the HI registers read 0 above NUM_IO.
    out_ext = '0;
    oeb_ext = '0;
    in_ext  = '0;
    out_ext[NUM_IO-1:0] = out_q;
    oeb_ext[NUM_IO-1:0] = oeb_q;
    in_ext[NUM_IO-1:0]  = s2_q;

    out_d = out_q;
    oeb_d = oeb_q;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      if (wr && wbs_sel_i[(i % 32) / 8]) begin
        if (reg_sel == ((i < 32) ? 3'd0 : 3'd1)) out_d[i] = wbs_dat_i[i % 32];
        if (reg_sel == ((i < 32) ? 3'd2 : 3'd3)) oeb_d[i] = wbs_dat_i[i % 32];
      end
    end

    irq_en_d = irq_en_q;
    if (wr && reg_sel == 3'd6) begin
      irq_en_d = (irq_en_q & ~lane_mask) | (wbs_dat_i & lane_mask);
    end

    // A rise in the same cycle as a W1C keeps the bit set.
    rise       = s2_q[31:0] & ~s3_q;
    w1c        = (wr && reg_sel == 3'd7) ? (wbs_dat_i & lane_mask) : 32'd0;
    irq_stat_d = (irq_stat_q & ~w1c) | rise;

    dat_d = 32'd0;
    if (rd) begin
      case (reg_sel)
        3'd0:    dat_d = out_ext[31:0];
        3'd1:    dat_d = out_ext[63:32];
        3'd2:    dat_d = oeb_ext[31:0];
        3'd3:    dat_d = oeb_ext[63:32];
        3'd4:    dat_d = in_ext[31:0];
        3'd5:    dat_d = in_ext[63:32];
        3'd6:    dat_d = irq_en_q;
        default: dat_d = irq_stat_q;
      endcase
    end

    ack_d = req;
    irq_d = |(irq_stat_q & irq_en_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q      <= '0;
      oeb_q      <= '1;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oeb_q      <= oeb_d;
      s1_q       <= io_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q[31:0];
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq       = irq_q;

endmodule
